// File: rtl/noc_matrix_arbiter_pkg.sv
// Shared types and helpers for the two-class matrix arbiter.
// Holds the lock FSM state type, age-width helper, matrix indexing and one-hot decode.
package noc_arb_pkg;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_t;

   localparam int MAX_N = 16;

   // Width of an age counter that must hold 0..age_max.
   function automatic int age_w(input int age_max);
      return (age_max < 1) ? 1 : $clog2(age_max + 1);
   endfunction

   // Bit position of prio[i][j] (i>j) in the flattened lower triangle.
   function automatic int tri_idx(input int i, input int j);
      return (i * (i - 1)) / 2 + j;
   endfunction

   function automatic logic [3:0] onehot2bin(input logic [MAX_N-1:0] oh);
      logic [3:0] b;
      b = '0;
      for (int k = 0; k < MAX_N; k++)
         if (oh[k]) b = b | 4'(k);
      return b;
   endfunction

endpackage

// File: rtl/noc_matrix_arbiter_if.sv
// Request/grant bundle between input-VC request logic and the output-port arbiter.
// master: requester side (drives req_hi/req_lo/tail/ready); slave: arbiter side.
interface noc_matrix_arbiter_if #(
   parameter int N = 8
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   logic [N-1:0]  req_hi;
   logic [N-1:0]  req_lo;
   logic [N-1:0]  tail;
   logic          ready;
   logic [N-1:0]  grant;
   logic          grant_valid;
   logic [IW-1:0] grant_idx;
   logic          locked;

   modport master (
      output req_hi, req_lo, tail, ready,
      input  grant, grant_valid, grant_idx, locked
   );

   modport slave (
      input  req_hi, req_lo, tail, ready,
      output grant, grant_valid, grant_idx, locked
   );

endinterface

// File: rtl/noc_matrix_arbiter_pick.sv
// Combinational matrix pick: one-hot winner among eff using the triangular prio matrix.
// Ports: eff (requests), prio (flattened prio[i][j], i>j), win (one-hot or zero).
module noc_matrix_pick
   import noc_arb_pkg::*;
#(
   parameter  int N  = 8,
   localparam int NP = N * (N - 1) / 2
) (
   input  logic [N-1:0]  eff,
   input  logic [NP-1:0] prio,
   output logic [N-1:0]  win
);

   always_comb begin
      logic ok;
      win = '0;
      for (int i = 0; i < N; i++) begin
         ok = eff[i];
         for (int j = 0; j < N; j++) begin
            if (j != i && eff[j]) begin
               if (i > j) ok = ok & prio[tri_idx(i, j)];
               else       ok = ok & ~prio[tri_idx(j, i)];
            end
         end
         win[i] = ok;
      end
   end

endmodule

// File: rtl/noc_matrix_arbiter.sv
// Two-class least-recently-granted matrix arbiter with wormhole lock and aging.
// Ports: clk, rst_n (async, active-low), bus (slave: req_hi/req_lo/tail/ready in,
// grant/grant_valid/grant_idx/locked out).
module noc_matrix_arbiter
   import noc_arb_pkg::*;
#(
   parameter int N       = 8,
   parameter int AGE_MAX = 15
) (
   input  logic               clk,
   input  logic               rst_n,
   noc_matrix_arbiter_if.slave bus
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int NP = N * (N - 1) / 2;
   localparam int AW = age_w(AGE_MAX);
   localparam bit AGE_EN = (AGE_MAX != 0);
   localparam logic [AW-1:0] AGE_TOP = AW'(AGE_MAX);

   arb_state_t    state_q, state_d;
   logic [IW-1:0] lock_idx_q, lock_idx_d;
   logic [NP-1:0] prio_q, prio_d;
   logic [AW-1:0] age_q [N];

   logic [N-1:0]  req;
   logic [N-1:0]  aged;
   logic [N-1:0]  hi;
   logic [N-1:0]  eff;
   logic [N-1:0]  win;
   logic [N-1:0]  lock_oh;
   logic [N-1:0]  grant;
   logic [IW-1:0] win_idx;
   logic [IW-1:0] grant_idx;
   logic          xfer;
   logic          win_xfer;

   assign req = bus.req_hi | bus.req_lo;

   always_comb begin
      aged = '0;
      for (int i = 0; i < N; i++)
         aged[i] = AGE_EN && bus.req_lo[i] && (age_q[i] == AGE_TOP);
   end

   // High class (explicit or promoted) masks the low class entirely.
   assign hi  = bus.req_hi | aged;
   assign eff = (|hi) ? hi : bus.req_lo;

   noc_matrix_pick #(.N(N)) u_pick (
      .eff  (eff),
      .prio (prio_q),
      .win  (win)
   );

   assign win_idx = IW'(onehot2bin(MAX_N'(win)));
   assign lock_oh = N'(1) << lock_idx_q;

   always_comb begin
      grant = '0;
      unique case (state_q)
         ARB_IDLE:   grant = win;
         ARB_LOCKED: grant = lock_oh & req;
      endcase
   end

   assign grant_idx = IW'(onehot2bin(MAX_N'(grant)));
   assign xfer      = (|grant) & bus.ready;
   assign win_xfer  = xfer && (state_q == ARB_IDLE);

   assign bus.grant       = grant;
   assign bus.grant_valid = |grant;
   assign bus.grant_idx   = grant_idx;
   assign bus.locked      = (state_q == ARB_LOCKED);

   always_comb begin
      state_d    = state_q;
      lock_idx_d = lock_idx_q;
      unique case (state_q)
         ARB_IDLE: begin
            if (win_xfer && !bus.tail[win_idx]) begin
               state_d    = ARB_LOCKED;
               lock_idx_d = win_idx;
            end
         end
         ARB_LOCKED: begin
            if (xfer && bus.tail[lock_idx_q])
               state_d = ARB_IDLE;
         end
      endcase
   end

   // Winner drops below everyone: its row bits clear, its column bits set.
   always_comb begin
      prio_d = prio_q;
      if (win_xfer) begin
         for (int i = 1; i < N; i++) begin
            for (int j = 0; j < i; j++) begin
               if (i == int'(win_idx)) prio_d[tri_idx(i, j)] = 1'b0;
               if (j == int'(win_idx)) prio_d[tri_idx(i, j)] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ARB_IDLE;
         lock_idx_q <= '0;
         prio_q     <= '1;
      end else begin
         state_q    <= state_d;
         lock_idx_q <= lock_idx_d;
         prio_q     <= prio_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) age_q[i] <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (!bus.req_lo[i] || (xfer && grant[i]))
               age_q[i] <= '0;
            else if (age_q[i] != AGE_TOP)
               age_q[i] <= age_q[i] + 1'b1;
         end
      end
   end

   a_grant_onehot0 : assert property (
      @(posedge clk) disable iff (!rst_n) $onehot0(grant)
   ) else $error("grant not one-hot: %b", grant);

endmodule

// File: tb/tb_noc_matrix_arbiter.sv
// Bench for noc_matrix_arbiter: directed cases plus random traffic vs an LRG timestamp model.
// Second instance with aging disabled covers the starvation case.
module tb_noc_matrix_arbiter;

   localparam int N    = 8;
   localparam int AMAX = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] req_hi = '0;
   logic [7:0] req_lo = '0;
   logic [7:0] tail = '0;
   logic       ready = 1'b0;

   int vectors = 0;
   int miscompares = 0;

   int stamp [N];
   int age [N];
   int tnow;
   bit m_lock;
   int m_idx;

   noc_matrix_arbiter_if #(.N(N)) bus ();
   noc_matrix_arbiter_if #(.N(N)) bus0 ();

   assign bus.req_hi  = req_hi;
   assign bus.req_lo  = req_lo;
   assign bus.tail    = tail;
   assign bus.ready   = ready;
   assign bus0.req_hi = req_hi;
   assign bus0.req_lo = req_lo;
   assign bus0.tail   = tail;
   assign bus0.ready  = ready;

   noc_matrix_arbiter #(.N(N), .AGE_MAX(AMAX)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   noc_matrix_arbiter #(.N(N), .AGE_MAX(0)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Least-recently-granted: the eligible requester with the oldest stamp wins.
   function automatic logic [7:0] model_grant();
      logic [7:0] rq, hv, ef;
      int best;
      rq = req_hi | req_lo;
      if (m_lock) return rq[m_idx] ? (8'(1) << m_idx) : 8'h00;
      hv = req_hi;
      for (int i = 0; i < N; i++)
         if (req_lo[i] && age[i] == AMAX) hv[i] = 1'b1;
      ef = (hv != 0) ? hv : req_lo;
      best = -1;
      for (int i = 0; i < N; i++)
         if (ef[i] && (best < 0 || stamp[i] < stamp[best])) best = i;
      return (best < 0) ? 8'h00 : (8'(1) << best);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         stamp[i] = -i;
         age[i]   = 0;
      end
      tnow   = 0;
      m_lock = 0;
      m_idx  = 0;
   endtask

   task automatic step(input logic [7:0] h, input logic [7:0] l,
                       input logic [7:0] t, input logic r);
      logic [7:0] eg;
      int w;
      @(negedge clk);
      req_hi = h;
      req_lo = l;
      tail   = t;
      ready  = r;
      #1;
      eg = model_grant();
      w = 0;
      for (int i = 0; i < N; i++) if (eg[i]) w = i;
      chk("grant", 32'(bus.grant), 32'(eg));
      chk("grant_valid", 32'(bus.grant_valid), 32'(eg != 0));
      chk("grant_idx", 32'(bus.grant_idx), 32'(w));
      chk("locked", 32'(bus.locked), 32'(m_lock));
      if (eg != 0 && r) begin
         if (!m_lock) begin
            tnow++;
            stamp[w] = tnow;
            if (!t[w]) begin
               m_lock = 1;
               m_idx  = w;
            end
         end else if (t[w]) begin
            m_lock = 0;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!l[i] || (eg[i] && r)) age[i] = 0;
         else if (age[i] < AMAX) age[i]++;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n  = 1'b0;
      req_hi = '0;
      req_lo = '0;
      tail   = '0;
      ready  = 1'b0;
      #1;
      chk("rst_locked", 32'(bus.locked), 32'(0));
      chk("rst_grant", 32'(bus.grant), 32'(0));
      chk("rst_idx", 32'(bus.grant_idx), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      logic [7:0] exp1 [9];
      exp1 = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08,
               8'h04, 8'h02, 8'h01, 8'h80};
      model_reset();

      // LRG rotation under full low-class load
      do_reset();
      for (int k = 0; k < 9; k++) begin
         step(8'h00, 8'hFF, 8'hFF, 1'b1);
         chk("t1_rot", 32'(bus.grant), 32'(exp1[k]));
      end

      // high class masks low class
      do_reset();
      step(8'h04, 8'h81, 8'hFF, 1'b1);
      chk("t2_hi", 32'(bus.grant), 32'(8'h04));
      chk("t2_idx", 32'(bus.grant_idx), 32'(2));
      step(8'h00, 8'h81, 8'hFF, 1'b1);
      chk("t2_lo", 32'(bus.grant), 32'(8'h80));

      // wormhole lock holds off a high-class request
      do_reset();
      step(8'h00, 8'h02, 8'h00, 1'b1);
      chk("t3_head", 32'(bus.grant), 32'(8'h02));
      step(8'h10, 8'h02, 8'h00, 1'b1);
      chk("t3_body", 32'(bus.grant), 32'(8'h02));
      chk("t3_lock", 32'(bus.locked), 32'(1));
      step(8'h10, 8'h02, 8'h02, 1'b1);
      chk("t3_tail", 32'(bus.grant), 32'(8'h02));
      step(8'h10, 8'h02, 8'h00, 1'b1);
      chk("t3_next", 32'(bus.grant), 32'(8'h10));
      chk("t3_unlock", 32'(bus.locked), 32'(0));

      // backpressure freezes the decision
      do_reset();
      for (int k = 0; k < 5; k++) begin
         step(8'h00, 8'h0C, 8'hFF, 1'b0);
         chk("t4_hold", 32'(bus.grant), 32'(8'h08));
      end
      step(8'h00, 8'h0C, 8'hFF, 1'b1);
      chk("t4_go0", 32'(bus.grant), 32'(8'h08));
      step(8'h00, 8'h0C, 8'hFF, 1'b1);
      chk("t4_go1", 32'(bus.grant), 32'(8'h04));

      // aging promotes a starved low-class requester; disabled instance starves it
      do_reset();
      for (int k = 0; k < 8; k++) begin
         step(8'h01, 8'h80, 8'hFF, 1'b1);
         chk("t5_age", 32'(bus.grant), 32'((k == 4) ? 8'h80 : 8'h01));
         chk("t5_noage", 32'(bus0.grant), 32'(8'h01));
      end

      // async reset in the middle of a packet
      do_reset();
      step(8'h00, 8'h02, 8'h00, 1'b1);
      step(8'h00, 8'h02, 8'h00, 1'b0);
      chk("t6_pre", 32'(bus.locked), 32'(1));
      do_reset();
      step(8'h00, 8'h81, 8'hFF, 1'b1);
      chk("t6_post", 32'(bus.grant), 32'(8'h80));

      // random traffic against the model
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         step(8'($urandom & $urandom & $urandom),
              8'($urandom),
              8'($urandom | $urandom),
              1'(($urandom_range(0, 3) != 0)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
